// File: rtl/mask_gen_fsm.sv
// Mutation-mask generator: builds MASK_COUNT masks of GENE_BIT bits, each with
// up to mutate_bits ones placed at pseudo-random positions from a 16-bit LFSR,
// then holds the set until the consumer signals mask_used.
module mask_gen_fsm #(
  parameter int          GENE_BIT   = 80,
  parameter int          MASK_COUNT = 16,
  parameter int          POS_BITS   = 7,
  parameter int          SEL_BITS   = 4,
  parameter int          FIT_BITS   = 10,
  parameter int          FIT_THRESH = 8,
  parameter logic [15:0] SEED       = 16'hACE1,
  localparam int         IDX_W      = $clog2(MASK_COUNT),
  localparam int         CNT_W      = $clog2(GENE_BIT + 1)
) (
  input  logic                CLOCK_50,
  input  logic                reset_n,
  input  logic                mask_used,
  input  logic [SEL_BITS-1:0] mutate_count_select,
  input  logic [FIT_BITS-1:0] best,
  input  logic [IDX_W-1:0]    mask_rd_idx,
  output logic [GENE_BIT-1:0] mask_rd_data,
  output logic                mask_ready,
  output logic [2:0]          state,
  output logic [IDX_W-1:0]    mask_count,
  output logic [CNT_W-1:0]    bit_count
);

  typedef enum logic [2:0] {
    INIT  = 3'd0,
    CHECK = 3'd1,
    SET   = 3'd2,
    NEXT  = 3'd3,
    READY = 3'd4
  } state_e;

  // Mutation count after reset, limited to the gene width.
  localparam int MB_RST = (10 > GENE_BIT) ? GENE_BIT : 10;

  state_e              state_q, state_d;
  logic                mask_ready_q, mask_ready_d;
  logic [IDX_W-1:0]    mask_count_q, mask_count_d;
  logic [CNT_W-1:0]    bit_count_q, bit_count_d;
  logic [CNT_W-1:0]    mutate_bits_q, mutate_bits_d;
  logic [15:0]         lfsr_q, lfsr_d;
  logic [GENE_BIT-1:0] masks_q [MASK_COUNT];
  logic [GENE_BIT-1:0] masks_d [MASK_COUNT];

  logic [15:0]         lfsr_next;
  logic [POS_BITS-1:0] raw_pos;
  logic [POS_BITS-1:0] pos;
  int                  mb_raw;
  logic [CNT_W-1:0]    mb_new;

  // LFSR step, folded bit position and the mutation count offered to the next generation.
  always_comb begin
    lfsr_next = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    raw_pos   = lfsr_q[POS_BITS-1:0];
    // Raw positions past the gene width wrap once; the position range is at most twice the width.
    pos       = (raw_pos < POS_BITS'(GENE_BIT)) ? raw_pos : raw_pos - POS_BITS'(GENE_BIT);
    if (best < FIT_BITS'(FIT_THRESH)) mb_raw = int'(mutate_count_select[2:0]) + 2;
    else                              mb_raw = int'(mutate_count_select) + 4;
    mb_new    = (mb_raw > GENE_BIT) ? CNT_W'(GENE_BIT) : CNT_W'(mb_raw);
  end

  // Next-state logic: walk the masks from the top index down, one bit per CHECK/SET pair.
  always_comb begin
    // NOTE: every _d gets its hold value first so no path through the case infers a latch.
    state_d       = state_q;
    mask_count_d  = mask_count_q;
    bit_count_d   = bit_count_q;
    mutate_bits_d = mutate_bits_q;
    lfsr_d        = lfsr_q;
    masks_d       = masks_q;
    case (state_q)
      INIT: begin
        masks_d      = '{default: '0};
        mask_count_d = IDX_W'(MASK_COUNT - 1);
        bit_count_d  = '0;
        state_d      = CHECK;
      end
      CHECK: state_d = (bit_count_q < mutate_bits_q) ? SET : NEXT;
      SET: begin
        masks_d[mask_count_q][pos] = 1'b1;
        bit_count_d = bit_count_q + CNT_W'(1);
        lfsr_d      = lfsr_next;
        state_d     = CHECK;
      end
      NEXT: begin
        bit_count_d = '0;
        if (mask_count_q == '0) begin
          state_d = READY;
        end else begin
          mask_count_d = mask_count_q - IDX_W'(1);
          state_d      = CHECK;
        end
      end
      READY: begin
        if (mask_used) begin
          mutate_bits_d = mb_new;
          state_d       = INIT;
        end
      end
      default: state_d = INIT;
    endcase
    mask_ready_d = (state_d == READY);
  end

  // State register with synchronous active-low reset overriding any build in progress.
  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      // NOTE: the mask store is reset explicitly because a freshly reset generator must read all-zero masks.
      state_q       <= INIT;
      mask_ready_q  <= 1'b0;
      mask_count_q  <= IDX_W'(MASK_COUNT - 1);
      bit_count_q   <= '0;
      mutate_bits_q <= CNT_W'(MB_RST);
      lfsr_q        <= SEED;
      masks_q       <= '{default: '0};
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values.
      state_q       <= state_d;
      mask_ready_q  <= mask_ready_d;
      mask_count_q  <= mask_count_d;
      bit_count_q   <= bit_count_d;
      mutate_bits_q <= mutate_bits_d;
      lfsr_q        <= lfsr_d;
      masks_q       <= masks_d;
    end
  end

  assign mask_rd_data = masks_q[mask_rd_idx];
  assign mask_ready   = mask_ready_q;
  assign state        = state_q;
  assign mask_count   = mask_count_q;
  assign bit_count    = bit_count_q;

endmodule

// File: doc/mask_gen_fsm.md
MASK_GEN_FSM -- requirements
Module: mask_gen_fsm

Interface
REQ-001 Parameter GENE_BIT, default 80: width of one mutation mask, in bits.
REQ-002 Parameter MASK_COUNT, default 16: number of masks produced per generation.
REQ-003 Parameter POS_BITS, default 7: width of a random bit position; 2^POS_BITS SHALL be >= GENE_BIT and <= 2*GENE_BIT.
REQ-004 Parameter SEL_BITS, default 4: width of mutate_count_select.
REQ-005 Parameter FIT_BITS, default 10: width of best.
REQ-006 Parameter FIT_THRESH, default 8: fitness threshold for selecting the small-mutation mode.
REQ-007 Parameter SEED, default 16'hACE1: 16-bit LFSR reset value; SHALL be nonzero.
REQ-008 CLOCK_50  in  1  sole clock; all state updates on its rising edge.
REQ-009 reset_n  in  1  reset, synchronous and active-low.
REQ-010 mask_used  in  1  consumer has taken the current mask set.
REQ-011 mutate_count_select  in  SEL_BITS  random mutation-count selector.
REQ-012 best  in  FIT_BITS  fitness of the current best gene.
REQ-013 mask_rd_idx  in  clog2(MASK_COUNT)  mask read index.
REQ-014 mask_rd_data  out  GENE_BIT  combinational read of mask[mask_rd_idx].
REQ-015 mask_ready  out  1  registered; high while a complete mask set is held.
REQ-016 state  out  3  current FSM state code.
REQ-017 mask_count  out  clog2(MASK_COUNT)  index of the mask being built.
REQ-018 bit_count  out  clog2(GENE_BIT+1)  bits placed so far in the current mask.

Function
REQ-019 The state codes SHALL be INIT=0, CHECK=1, SET=2, NEXT=3, READY=4; codes 5-7 SHALL return to INIT on the next cycle.
REQ-020 INIT: clear all masks; set mask_count to MASK_COUNT-1 and bit_count to 0; go to CHECK; mask_ready SHALL be 0.
REQ-021 CHECK: if bit_count < mutate_bits, go to SET; otherwise go to NEXT.
REQ-022 SET: set bit pos of mask[mask_count]; increment bit_count; step the LFSR; go to CHECK.
REQ-023 Position: raw = LFSR[POS_BITS-1:0]; pos = raw if raw < GENE_BIT, else raw - GENE_BIT; no bit at index >= GENE_BIT SHALL ever be set.
REQ-024 The LFSR SHALL be a 16-bit Fibonacci LFSR with taps 16,14,13,11 that steps only in SET.
REQ-025 A repeated position SHALL leave the bit set; each mask SHALL therefore hold between 1 and mutate_bits ones (or 0 ones if mutate_bits is 0).
REQ-026 NEXT: clear bit_count; if mask_count is 0, go to READY; otherwise decrement mask_count and go to CHECK.
REQ-027 READY: mask_ready is 1; masks SHALL be held stable; go to INIT when mask_used is 1, with mask_ready reading 0 on the following cycle.
REQ-028 mask_used SHALL be ignored in every state other than READY.
REQ-029 mutate_bits (internal) SHALL be latched only on the READY->INIT transition: sel[2:0]+2 if best < FIT_THRESH, else sel+4, then clamped to GENE_BIT.
REQ-030 Generation latency from INIT to READY SHALL be exactly 1 + MASK_COUNT*(2*mutate_bits+2) cycles.
REQ-031 mask_rd_data SHALL be valid only while mask_ready is 1; during a build it reflects partial contents.

Reset
REQ-032 When reset_n is 0 at a clock edge, the following SHALL apply on that edge, overriding every other action including a build in progress: state=INIT, mask_ready=0, mask_count=MASK_COUNT-1, bit_count=0, mutate_bits=10 (clamped to GENE_BIT), LFSR=SEED, all masks=0.

Verification
REQ-033 Release reset with defaults -> mask_ready rises exactly 353 cycles after the first INIT cycle; every mask has popcount in 1..10 and no bit set at index >= 80.
REQ-034 In READY, drive best=5, sel=4'b1011, mask_used=1 for one cycle -> mutate_bits=5; mask_ready=0 next cycle; READY reached again after 193 cycles; every popcount <= 5.
REQ-035 In READY, drive best=20, sel=4'hF, pulse mask_used -> mutate_bits=19; latency is 641 cycles.
REQ-036 Hold mask_used=1 continuously from reset -> no effect during the build; exactly one READY cycle per generation; generations repeat back to back.
REQ-037 Assert reset_n=0 for one cycle during SET of mask 7 -> next cycle state=INIT, all masks 0, mask_ready=0; the following build reproduces the post-reset masks of REQ-033.
REQ-038 Instantiate GENE_BIT=12, POS_BITS=4, and drive best=20, sel=4'hF -> mutate_bits clamped to 12; raw positions 12-15 fold to 0-3; all 16 masks remain within [11:0].
